// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and sizing rules for the sequential multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Counter must be able to hold W itself, not just W-1.
  function automatic int mul_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cneg_w.sv
// rtl/cneg_w.sv - conditional two's-complement negate: out = neg ? -in : in
module cneg_w #(
  parameter int N = 8
) (
  input  logic [N-1:0] in_i,
  input  logic         neg_i,
  output logic [N-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + N'(1)) : in_i;

endmodule

// File: rtl/mul_seq_shadd.sv
// rtl/mul_seq_shadd.sv - W-cycle shift-add multiplier with start/busy/done handshake
// Optional signed mode (SGN port) is compiled in with MUL_SEQ_SIGNED_EN.
module mul_seq_shadd
  import mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [W-1:0]   INA,
  input  logic [W-1:0]   INB,
`ifdef MUL_SEQ_SIGNED_EN
  input  logic           SGN,
`endif
  output logic           BUSY,
  output logic           DONE,
  output logic [2*W-1:0] RES
);

  localparam int CW = mul_cnt_w(W);

  mul_state_t     state_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [2*W-1:0] res_q;
  logic [2*W-1:0] res_d;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   a_cap;
  logic [W-1:0]   b_cap;
  logic           last_run;

  assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_run = (cnt_q == CW'(W - 1));

`ifdef MUL_SEQ_SIGNED_EN
  logic neg_q;
  logic neg_d;

  // Magnitudes at capture; the most negative value maps onto 2^(W-1), which still fits.
  cneg_w #(.N(W)) u_neg_a (
    .in_i  (INA),
    .neg_i (SGN & INA[W-1]),
    .out_o (a_cap)
  );

  cneg_w #(.N(W)) u_neg_b (
    .in_i  (INB),
    .neg_i (SGN & INB[W-1]),
    .out_o (b_cap)
  );

  cneg_w #(.N(2*W)) u_neg_res (
    .in_i  (acc_d),
    .neg_i (neg_q),
    .out_o (res_d)
  );

  assign neg_d = SGN & (INA[W-1] ^ INB[W-1]);
`else
  assign a_cap = INA;
  assign b_cap = INB;
  assign res_d = acc_d;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        MUL_IDLE, MUL_DONE: begin
          done_q <= 1'b0;
          if (START) begin
            mcand_q  <= {{W{1'b0}}, a_cap};
            mplier_q <= b_cap;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            neg_q    <= neg_d;
`endif
            state_q  <= MUL_RUN;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= MUL_IDLE;
            busy_q   <= 1'b0;
          end
        end
        MUL_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_run) begin
            res_q   <= res_d;
            state_q <= MUL_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= MUL_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign RES  = res_q;

endmodule

// File: tb/tb_mul_seq_shadd.sv
// tb/tb_mul_seq_shadd.sv - self-checking bench for mul_seq_shadd against an arithmetic model
module tb_mul_seq_shadd;

  localparam int W = 8;

  logic           CLK;
  logic           RST;
  logic           START;
  logic [W-1:0]   INA;
  logic [W-1:0]   INB;
`ifdef MUL_SEQ_SIGNED_EN
  logic           SGN;
`endif
  logic           BUSY;
  logic           DONE;
  logic [2*W-1:0] RES;

  int n_checks;
  int n_fail;

  mul_seq_shadd #(.W(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .INA   (INA),
    .INB   (INB),
`ifdef MUL_SEQ_SIGNED_EN
    .SGN   (SGN),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .RES   (RES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [2*W-1:0] model_u(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  function automatic logic [2*W-1:0] model_s(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint p;
    sa = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
    sb = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Drives one START pulse; returns at the falling edge of the first RUN cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    INA   = a;
    INB   = b;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Full timing + result check for one operation, entered right after issue().
  task automatic run_and_check(input string tag, input logic [2*W-1:0] exp);
    for (int c = 1; c <= W; c++) begin
      n_checks++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b, required busy=1 done=0", tag, c, BUSY, DONE);
      end
      @(negedge CLK);
    end
    n_checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || RES !== exp) begin
      n_fail++;
      $display("FAIL %s done cycle: done=%b busy=%b res=%0d, required done=1 busy=0 res=%0d",
               tag, DONE, BUSY, RES, exp);
    end
    @(negedge CLK);
    n_checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || RES !== exp) begin
      n_fail++;
      $display("FAIL %s after done: done=%b busy=%b res=%0d, required done=0 busy=0 res=%0d",
               tag, DONE, BUSY, RES, exp);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    START = 1'b0;
    INA = '0;
    INB = '0;
`ifdef MUL_SEQ_SIGNED_EN
    SGN = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RES !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b res=%0d, required 0 0 0", BUSY, DONE, RES);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RES !== '0) begin
      n_fail++;
      $display("FAIL idle after reset: busy=%b done=%b res=%0d, required 0 0 0", BUSY, DONE, RES);
    end
  endtask

  task automatic test_basic();
    issue(8'd15, 8'd15);
    run_and_check("basic 15*15", 16'd225);
    repeat (3) @(negedge CLK);
    n_checks++;
    if (RES !== 16'd225) begin
      n_fail++;
      $display("FAIL basic hold: res=%0d, required 225", RES);
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    av = '{8'd255, 8'd0, 8'd1};
    bv = '{8'd255, 8'd200, 8'd255};
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i]);
      run_and_check($sformatf("extreme %0d*%0d", av[i], bv[i]), model_u(av[i], bv[i]));
    end
  endtask

  task automatic test_ignore_during_run();
    logic [2*W-1:0] exp;
    exp = model_u(8'd12, 8'd13);
    issue(8'd12, 8'd13);
    for (int c = 1; c <= W; c++) begin
      START = (c < W);
      INA   = W'($urandom);
      INB   = W'($urandom);
      @(negedge CLK);
    end
    START = 1'b0;
    n_checks++;
    if (DONE !== 1'b1 || RES !== exp) begin
      n_fail++;
      $display("FAIL ignore during run: done=%b res=%0d, required done=1 res=%0d", DONE, RES, exp);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int first_done;
    int second_done;
    first_done  = -1;
    second_done = -1;
    @(negedge CLK);
    INA   = 8'd3;
    INB   = 8'd7;
    START = 1'b1;
    for (int c = 1; c <= 2 * (W + 1); c++) begin
      @(negedge CLK);
      if (c == 1) begin
        INA = 8'd9;
        INB = 8'd9;
      end
      if (c == 2 * (W + 1)) START = 1'b0;
      if (DONE === 1'b1) begin
        if (first_done < 0) begin
          first_done = c;
          n_checks++;
          if (RES !== 16'd21) begin
            n_fail++;
            $display("FAIL back-to-back first: res=%0d, required 21", RES);
          end
        end else begin
          second_done = c;
          n_checks++;
          if (RES !== 16'd81) begin
            n_fail++;
            $display("FAIL back-to-back second: res=%0d, required 81", RES);
          end
        end
      end
      n_checks++;
      if (BUSY === 1'b1 && DONE === 1'b1) begin
        n_fail++;
        $display("FAIL back-to-back overlap at cycle %0d: busy=1 done=1, required exclusive", c);
      end
    end
    n_checks++;
    if (first_done != W + 1 || second_done != 2 * (W + 1)) begin
      n_fail++;
      $display("FAIL back-to-back timing: done at %0d and %0d, required %0d and %0d",
               first_done, second_done, W + 1, 2 * (W + 1));
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    issue(8'd200, 8'd3);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RES !== '0) begin
      n_fail++;
      $display("FAIL reset mid-run: busy=%b done=%b res=%0d, required 0 0 0", BUSY, DONE, RES);
    end
    @(negedge CLK);
    RST = 1'b0;
    seen_done = 0;
    repeat (W + 3) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done != 0 || RES !== '0) begin
      n_fail++;
      $display("FAIL after abort: %0d busy/done cycles, res=%0d, required 0 and 0", seen_done, RES);
    end
    issue(8'd6, 8'd7);
    run_and_check("post-abort 6*7", 16'd42);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      issue(a, b);
      run_and_check($sformatf("random %0d*%0d", a, b), model_u(a, b));
    end
  endtask

`ifdef MUL_SEQ_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic [2*W-1:0] ev [3];
    logic [W-1:0] a;
    logic [W-1:0] b;
    av = '{8'hFD, 8'h80, 8'h7F};
    bv = '{8'h05, 8'h80, 8'h80};
    ev = '{16'hFFF1, 16'h4000, 16'hC080};
    SGN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (model_s(av[i], bv[i]) !== ev[i]) begin
        n_fail++;
        $display("FAIL signed model %0d: got %h, required %h", i, model_s(av[i], bv[i]), ev[i]);
      end
      issue(av[i], bv[i]);
      run_and_check($sformatf("signed %h*%h", av[i], bv[i]), ev[i]);
    end
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      issue(a, b);
      run_and_check($sformatf("signed random %h*%h", a, b), model_s(a, b));
    end
    SGN = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_ignore_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
`ifdef MUL_SEQ_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_shadd.md
# mul_seq_shadd

Parametrised sequential shift-add multiplier producing a full-width `2W`-bit product from two `W`-bit operands, one multiplier bit per clock. It is the multi-cycle successor to the team's combinational 4-bit multiplier. It trades area for latency and adds a start/busy/done handshake so arithmetic units and datapaths can issue multiplies without a wide combinational array.

## Interface
- `W`, default 8: operand width, minimum 2; product width is `2*W`.
- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `START`  in  1  request; sampled only in IDLE or DONE state.
- `INA`  in  W  multiplicand, captured on accepted START.
- `INB`  in  W  multiplier, captured on accepted START.
- `SGN`  in  1  signed mode select, captured on accepted START (present only with `MUL_SEQ_SIGNED_EN`).
- `BUSY`  out  1  high while in RUN.
- `DONE`  out  1  one-cycle pulse, high in DONE state.
- `RES`  out  2W  product register; updated only on entry to DONE.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, counter 0, accumulator 0, `RES=0`, `BUSY=0`, `DONE=0`.
- IDLE: `START=1` latches `INA` into a `2W`-bit shifted multiplicand and `INB` into a `W`-bit shift register; clears the accumulator and counter; goes to RUN.
- RUN, per cycle: if multiplier LSB is 1, accumulator += shifted multiplicand (mod `2^(2W)`, never overflows for unsigned). Multiplicand shifts left 1. Multiplier shifts right 1. Counter increments.
- After the `W`-th RUN cycle: the final accumulator value is written to `RES` and the state goes to DONE.
- DONE: lasts one cycle. `START=1` here is accepted exactly as in IDLE (back-to-back, to RUN). Otherwise the state goes to IDLE.
- `START` in RUN is ignored; operand inputs may change freely during RUN.
- `RES` holds its value through IDLE and through the next RUN, until the next DONE entry.
- `RST` asserted mid-RUN aborts the operation immediately. No DONE pulse follows, and `RES` returns to 0.

## Timing
- Accepted START at edge `k`: `BUSY=1` for cycles `k+1 .. k+W`. `DONE=1` and the new `RES` are valid in cycle `k+W+1`.
- Latency is START-to-DONE `W+1` clocks, fixed and independent of operand values.
- Throughput: one result per `W+1` clocks with START held or re-asserted in DONE.
- `BUSY` and `DONE` are never high together. `DONE` is never high for two consecutive cycles.

## Configuration
- `MUL_SEQ_SIGNED_EN` defined: adds the `SGN` port.
  - With `SGN=1`, operands are two's complement. Their magnitudes are taken at capture and the result sign is `INA[W-1]^INB[W-1]`. The unsigned magnitude product is negated when writing `RES` if the sign is 1.
  - `-2^(W-1)` is handled: its magnitude `2^(W-1)` fits in `W` unsigned bits.
  - Latency is unchanged.
  - `SGN=0` behaves exactly like the unsigned build.
- Macro undefined: no `SGN` port, unsigned only, no negation logic.

## Structure
- The shared package `mul_pkg` holds:
  - the state encoding constants `MUL_IDLE`, `MUL_RUN`, `MUL_DONE` (2-bit);
  - the counter width rule `$clog2(W+1)`.
- The sub-module `cneg_w` (parametrised conditional two's-complement negate, `out = neg ? -in : in`) is natural. It is instantiated for both operands (width `W`) and the result (width `2W`) when signed mode is compiled in.
- The FSM, counter and shift/accumulate datapath stay in `mul_seq_shadd`.

## Test plan
All scenarios use `W=8` unless noted.
- Reset, then `INA=15`, `INB=15`, START for 1 cycle: `BUSY` is high for 8 cycles, `DONE` pulses on the 9th cycle, `RES=225`, and `RES` holds after `DONE` falls.
- Extremes: `255*255` gives `RES=65025`. `0*200` gives `RES=0`. `1*255` gives `RES=255`. Each has `DONE` exactly 9 cycles after START.
- START re-asserted and `INA`/`INB` changed during RUN: these are ignored, and the result matches the originally captured operands.
- START held high continuously with `3*7` then `9*9`: back-to-back results `21` then `81`, with `DONE` pulses 9 cycles apart.
- `RST` pulsed in the 4th RUN cycle: `BUSY`, `DONE` and `RES` go to 0 asynchronously, no `DONE` follows, and the next START works normally.
- With `MUL_SEQ_SIGNED_EN` and `SGN=1`: `-3*5` gives `RES=16'hFFF1`, `-128*-128` gives `RES=16'h4000`, and `127*-128` gives `RES=16'hC080`.
